slice_sequencer: RTL and testbench
==================================

# slice_sequencer

Top-level scheduler for the LED driver datapath. Runs the column-multiplexed refresh: per column, a fixed-length poker-mode stream window, then a blanking window with a latch pulse. Gates the framebuffer with `driver_ready`, drives the column one-hot enable, and inserts driver configuration loads only at slice boundaries. Sits between the configuration block and the framebuffer/driver main controller pair.

## Interface
Parameters:
- POKER_MODE, 9, bits sent per colour per LED
- LED_PER_DRIVER, 16, LEDs per driver chain
- MUX_COUNT, 8, multiplexed columns per slice
- BLANKING_CYCLES, 72, blanking window length in cycles, must be ≥ 2

Ports:
- clk_33  in  1  system clock; one clock, reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- enable  in  1  streaming allowed
- new_configuration_ready  in  1  config word available; pulse or level
- config_done  in  1  driver controller has finished shifting config
- config_load  out  1  request to shift config into the drivers
- driver_ready  out  1  stream window; framebuffer advances its counters when high
- lat  out  1  one-cycle latch strobe
- mux_en  out  MUX_COUNT  one-hot column enable
- mul_idx  out  $clog2(MUX_COUNT)  current column
- slice_start  out  1  pulse on the first stream cycle of column 0

## Operation
- STREAM_CYCLES = 3*LED_PER_DRIVER*POKER_MODE, which is 432 by default. The cycle counter width is $clog2(max(STREAM_CYCLES, BLANKING_CYCLES)).
- States are IDLE, CONFIG, STREAM and BLANK. Reset enters IDLE with mul_idx=0, the counter at 0, the pending flag at 0, and every output at 0.
- Pending flag:
  - Set on any cycle where new_configuration_ready=1.
  - Cleared on the cycle config_done=1 in CONFIG.
  - If a set and a clear happen in the same cycle, the set wins.
- IDLE: if pending, go to CONFIG. Otherwise, if enable, go to STREAM. Otherwise stay.
- CONFIG: config_load=1 and driver_ready=0.
  - On config_done, go to STREAM if enable, else go to IDLE.
  - config_done outside CONFIG is ignored.
- STREAM: driver_ready=1 and mux_en=1<<mul_idx. Stays for exactly STREAM_CYCLES cycles, then goes to BLANK. The enable input is ignored mid-window.
- BLANK: driver_ready=0 and mux_en=0. lat=1 on the first BLANK cycle only. Stays for BLANKING_CYCLES cycles. On the last cycle:
  - mul_idx ≠ MUX_COUNT-1: mul_idx+1, then STREAM.
  - mul_idx = MUX_COUNT-1 (slice boundary): mul_idx wraps to 0. Next state has priority: pending → CONFIG, else enable → STREAM, else IDLE.
- Config loads and stops happen only at slice boundaries. A slice is never truncated.

## Timing
- All outputs are Moore, decoded from registered state, counter and mul_idx. There is no combinational input→output path.
- With defaults, enable=1 sampled in IDLE at cycle N:
  - STREAM runs N+1..N+432; driver_ready=1 throughout, slice_start=1 at N+1.
  - BLANK runs N+433..N+504; lat=1 at N+433.
  - Column 1 STREAM starts at N+505.
- Column period is STREAM_CYCLES+BLANKING_CYCLES, which is 504 by default. Slice period is MUX_COUNT×504 = 4032.
- CONFIG: config_load rises one cycle after the deciding edge. It falls the cycle after config_done is sampled; STREAM or IDLE takes effect that same cycle.
- rst=1 mid-operation: all outputs are 0 at the next edge and the pending request is dropped.

## Configuration
- SEQ_SLICE_CNT_EN defined:
  - Adds output slice_cnt [15:0], reset 0.
  - It increments on each mul_idx wrap (last BLANK cycle of column MUX_COUNT-1) and wraps 0xFFFF→0.
- SEQ_SLICE_CNT_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package seq_pkg holds:
  - seq_state_t, an enum of IDLE, CONFIG, STREAM, BLANK;
  - the STREAM_CYCLES derivation function.
- No sub-module. The one-hot decode and the counters are inline.

## Test plan
- Reset, then enable=1 at cycle 0:
  - driver_ready high for exactly 432 cycles (1..432);
  - lat pulse only at 433;
  - mux_en=8'h01 in stream and 8'h00 in blank;
  - column 1 stream starts at 505.
- Full slice: mul_idx steps 0..7 and wraps to 0; slice_start pulses every 4032 cycles. With SEQ_SLICE_CNT_EN, slice_cnt=1 after the first wrap.
- new_configuration_ready pulse in column 3: no config_load until the end of column 7 blank. Then config_load=1, held until config_done asserts 5 cycles later; STREAM resumes the next cycle with mul_idx=0.
- Simultaneous new_configuration_ready and config_done: a second CONFIG follows immediately after the next slice.
- enable drops mid-column 2: the slice completes through column 7, then IDLE with all outputs 0.
- rst asserted mid-STREAM of column 5 with a pending config: the next cycle is IDLE, mul_idx=0, driver_ready=0, and no CONFIG follows.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the column-multiplexed LED refresh sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    STREAM = 2'd2,
    BLANK  = 2'd3
  } seq_state_t;

  // Three colours per LED, POKER_MODE bits per colour, one LED per chain slot.
  function automatic int stream_cycles(input int poker_mode, input int led_per_driver);
    return 3 * led_per_driver * poker_mode;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slice_sequencer.sv
// Column-multiplexed refresh scheduler: stream window, blanking with latch, config loads at slice boundaries.
// Optional build macro SEQ_SLICE_CNT_EN adds a free-running 16-bit slice counter output.
module slice_sequencer
  import seq_pkg::*;
#(
  parameter int POKER_MODE      = 9,
  parameter int LED_PER_DRIVER  = 16,
  parameter int MUX_COUNT       = 8,
  parameter int BLANKING_CYCLES = 72
) (
  input  logic                         clk_33,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         new_configuration_ready,
  input  logic                         config_done,
  output logic                         config_load,
  output logic                         driver_ready,
  output logic                         lat,
  output logic [MUX_COUNT-1:0]         mux_en,
  output logic [$clog2(MUX_COUNT)-1:0] mul_idx,
  output logic                         slice_start
`ifdef SEQ_SLICE_CNT_EN
  ,
  output logic [15:0]                  slice_cnt
`endif
);

  localparam int STREAM_CYCLES = stream_cycles(POKER_MODE, LED_PER_DRIVER);
  localparam int CNT_W         = $clog2(max_int(STREAM_CYCLES, BLANKING_CYCLES));
  localparam int IDX_W         = $clog2(MUX_COUNT);

  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANKING_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(MUX_COUNT - 1);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] mul_idx_next;
  logic             pending, pending_next;
  logic             stream_last, blank_last, slice_wrap;

  assign stream_last = (state == STREAM) && (cnt == STREAM_LAST);
  assign blank_last  = (state == BLANK)  && (cnt == BLANK_LAST);
  assign slice_wrap  = blank_last && (mul_idx == IDX_LAST);

  // A request arriving on the same cycle the drivers finish wins, so it is never lost.
  always_comb begin
    pending_next = pending;
    if (new_configuration_ready) begin
      pending_next = 1'b1;
    end else if ((state == CONFIG) && config_done) begin
      pending_next = 1'b0;
    end
  end

  // NOTE: every combinational output is given a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    mul_idx_next = mul_idx;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (pending) begin
          state_next = CONFIG;
        end else if (enable) begin
          state_next = STREAM;
        end
      end
      CONFIG: begin
        cnt_next = '0;
        if (config_done) begin
          state_next = enable ? STREAM : IDLE;
        end
      end
      STREAM: begin
        if (stream_last) begin
          state_next = BLANK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BLANK: begin
        if (blank_last) begin
          cnt_next = '0;
          if (mul_idx != IDX_LAST) begin
            mul_idx_next = mul_idx + 1'b1;
            state_next   = STREAM;
          end else begin
            // Slice boundary: the only point where a config load or a stop may happen.
            mul_idx_next = '0;
            if (pending) begin
              state_next = CONFIG;
            end else if (enable) begin
              state_next = STREAM;
            end else begin
              state_next = IDLE;
            end
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        cnt_next     = '0;
        mul_idx_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_33) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mul_idx <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      mul_idx <= mul_idx_next;
      pending <= pending_next;
    end
  end

  // Moore decode from registered state only; no input reaches an output combinationally.
  always_comb begin
    config_load  = 1'b0;
    driver_ready = 1'b0;
    lat          = 1'b0;
    slice_start  = 1'b0;
    mux_en       = '0;
    case (state)
      CONFIG: config_load = 1'b1;
      STREAM: begin
        driver_ready = 1'b1;
        mux_en       = MUX_COUNT'(1) << mul_idx;
        slice_start  = (cnt == '0) && (mul_idx == '0);
      end
      BLANK:   lat = (cnt == '0);
      default: ;
    endcase
  end

`ifdef SEQ_SLICE_CNT_EN
  always_ff @(posedge clk_33) begin
    if (rst) begin
      slice_cnt <= '0;
    end else if (slice_wrap) begin
      slice_cnt <= slice_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_slice_sequencer.sv
// Self-checking bench for slice_sequencer: table of first-column expectations plus multi-slice corner sequences.
module tb_slice_sequencer;

  logic       clk_33 = 1'b0;
  logic       rst;
  logic       enable;
  logic       new_configuration_ready;
  logic       config_done;
  logic       config_load;
  logic       driver_ready;
  logic       lat;
  logic [7:0] mux_en;
  logic [2:0] mul_idx;
  logic       slice_start;
`ifdef SEQ_SLICE_CNT_EN
  logic [15:0] slice_cnt;
`endif

  always #5 clk_33 = ~clk_33;

  slice_sequencer dut (
    .clk_33                  (clk_33),
    .rst                     (rst),
    .enable                  (enable),
    .new_configuration_ready (new_configuration_ready),
    .config_done             (config_done),
    .config_load             (config_load),
    .driver_ready            (driver_ready),
    .lat                     (lat),
    .mux_en                  (mux_en),
    .mul_idx                 (mul_idx),
    .slice_start             (slice_start)
`ifdef SEQ_SLICE_CNT_EN
    ,
    .slice_cnt               (slice_cnt)
`endif
  );

  localparam int COL  = 504;
  localparam int STRM = 432;

  typedef struct {
    int         cyc;
    logic       cl;
    logic       dr;
    logic       lt;
    logic       ss;
    logic [7:0] mux;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cl_cnt, dr_cnt, lat_cnt, ss_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic cl, input logic dr, input logic lt,
                      input logic ss, input logic [7:0] mux, input logic [2:0] idx);
    exp_t e;
    e.cyc = c; e.cl = cl; e.dr = dr; e.lt = lt; e.ss = ss; e.mux = mux; e.idx = idx;
    sb.push_back(e);
  endtask

  // Four landmark cycles of one column: stream start/end, blank start/end.
  task automatic push_column(input int base, input int c);
    logic [7:0] m;
    m = 8'h01 << c;
    push(base + 1 + c*COL,          1'b0, 1'b1, 1'b0, (c == 0), m,     3'(c));
    push(base + STRM + c*COL,       1'b0, 1'b1, 1'b0, 1'b0,     m,     3'(c));
    push(base + STRM + 1 + c*COL,   1'b0, 1'b0, 1'b1, 1'b0,     8'h00, 3'(c));
    push(base + COL + c*COL,        1'b0, 1'b0, 1'b0, 1'b0,     8'h00, 3'(c));
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk_33);
    #1;
    cyc++;
    if (config_load)  cl_cnt++;
    if (driver_ready) dr_cnt++;
    if (lat)          lat_cnt++;
    if (slice_start)  ss_cnt++;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check($sformatf("missed_record_c%0d", e.cyc), 32'(cyc), 32'(e.cyc));
      end else begin
        check($sformatf("outputs_c%0d {cl,dr,lat,ss,mux,idx}", cyc),
              32'({config_load, driver_ready, lat, slice_start, mux_en, mul_idx}),
              32'({e.cl, e.dr, e.lt, e.ss, e.mux, e.idx}));
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    new_configuration_ready = 1'b0;
    config_done = 1'b0;
    sb.delete();
    step();
    step();
    check("reset_outputs", 32'({config_load, driver_ready, lat, slice_start, mux_en, mul_idx}), 32'd0);
`ifdef SEQ_SLICE_CNT_EN
    check("reset_slice_cnt", 32'(slice_cnt), 32'd0);
`endif
    rst = 1'b0;
    cyc = 0;
    cl_cnt = 0; dr_cnt = 0; lat_cnt = 0; ss_cnt = 0;
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  exp_t tbl[7];

  initial begin
    // First-column landmarks after enable is sampled at cycle 0.
    tbl[0] = '{1,   1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0};
    tbl[1] = '{2,   1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 3'd0};
    tbl[2] = '{216, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 3'd0};
    tbl[3] = '{432, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 3'd0};
    tbl[4] = '{433, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[5] = '{434, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[6] = '{504, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};

    // Test 1 + 2: first column timing, then the full slice and wrap.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 7; i++) sb.push_back(tbl[i]);
    run_to(504);
    check("col0_driver_ready_cycles", 32'(dr_cnt), 32'd432);
    check("col0_lat_pulses", 32'(lat_cnt), 32'd1);
    for (int c = 1; c < 8; c++) push_column(0, c);
    run_to(4032);
    check("slice_driver_ready_cycles", 32'(dr_cnt), 32'(8*STRM));
    check("slice_lat_pulses", 32'(lat_cnt), 32'd8);
    check("slice_start_pulses_first", 32'(ss_cnt), 32'd1);
`ifdef SEQ_SLICE_CNT_EN
    check("slice_cnt_before_wrap", 32'(slice_cnt), 32'd0);
`endif
    push(4033, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0);
    step();
    check("slice_start_pulses_second", 32'(ss_cnt), 32'd2);
`ifdef SEQ_SLICE_CNT_EN
    check("slice_cnt_after_wrap", 32'(slice_cnt), 32'd1);
`endif
    check_drained("t1_scoreboard_drained");

    // Test 3: config request in column 3 waits for the slice boundary.
    do_reset();
    enable = 1'b1;
    push(1613, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 3'd3);
    push(4032, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
    push(4033, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    push(4038, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    push(4039, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0);
    push(5001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1);
    push(8071, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0);
    run_to(1612);
    new_configuration_ready = 1'b1;
    step();
    new_configuration_ready = 1'b0;
    run_to(4032);
    check("t3_no_config_before_boundary", 32'(cl_cnt), 32'd0);
    run_to(4038);
    config_done = 1'b1;
    step();
    config_done = 1'b0;
    run_to(5000);
    config_done = 1'b1;  // outside CONFIG: must be ignored
    step();
    config_done = 1'b0;
    run_to(8071);
    check("t3_config_load_cycles", 32'(cl_cnt), 32'd6);
    check_drained("t3_scoreboard_drained");

    // Test 4: request coinciding with config_done forces a second CONFIG after the next slice.
    do_reset();
    new_configuration_ready = 1'b1;
    step();
    new_configuration_ready = 1'b0;
    enable = 1'b1;
    push(2,    1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    push(4,    1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    push(5,    1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0);
    push(4036, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
    push(4037, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    push(4038, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0);
    check("t4_idle_before_config", 32'({config_load, driver_ready}), 32'd0);
    run_to(4);
    config_done = 1'b1;
    new_configuration_ready = 1'b1;
    step();
    config_done = 1'b0;
    new_configuration_ready = 1'b0;
    run_to(4037);
    config_done = 1'b1;
    step();
    config_done = 1'b0;
    check("t4_config_load_cycles", 32'(cl_cnt), 32'd4);
    check_drained("t4_scoreboard_drained");

    // Test 5: enable drops in column 2; slice completes, then IDLE.
    do_reset();
    enable = 1'b1;
    push(1 + 7*COL, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 3'd7);
    push(4032,      1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
    push(4033,      1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    push(4100,      1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    run_to(2*COL + 200);
    enable = 1'b0;
    run_to(4100);
    check("t5_driver_ready_cycles", 32'(dr_cnt), 32'(8*STRM));
    check("t5_lat_pulses", 32'(lat_cnt), 32'd8);
    check_drained("t5_scoreboard_drained");

    // Test 6: reset mid-column 5 with a pending request drops the request.
    do_reset();
    enable = 1'b1;
    push(2701, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    push(2702, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0);
    push(6733, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7);
    push(6734, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0);
    run_to(1100);
    new_configuration_ready = 1'b1;
    step();
    new_configuration_ready = 1'b0;
    run_to(2700);
    check("t6_in_column5_stream", 32'({driver_ready, mul_idx}), 32'({1'b1, 3'd5}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_to(6734);
    check("t6_no_config_after_reset", 32'(cl_cnt), 32'd0);
    check_drained("t6_scoreboard_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
